// File: rtl/uds_pulse_gen.sv
// uds_pulse_gen: turns two raw push-buttons (up / down) into one-cycle command strobes for a
// downstream up/down/set counter.
//
// Each raw button passes through a 2-flop synchronizer and then an independent debouncer. A
// small FSM watches the two debounced levels:
//   - pressing one button pulses up or down once;
//   - having both buttons down at the same time pulses set once;
//   - releasing returns the FSM to idle without a pulse.
//
// Latency: a raw change that is first sampled at clock edge k and then held produces its strobe
// at edge k + debounce_cycles_p + 3. The stages are: two synchronizer flops, the debounce run of
// debounce_cycles_p + 1 differing samples, and the registered output.
//
// Optional feature (macro UDS_PULSE_GEN_AUTO_REPEAT_EN):
//   When the macro is defined, holding a single button auto-repeats its strobe. The first repeat
//   comes repeat_delay_p cycles after the entry pulse, and later repeats every repeat_rate_p
//   cycles. When the macro is undefined, there is no repeat timer at all and each press yields
//   exactly one pulse.
//
// Parameters:
//   debounce_cycles_p  stable cycles needed before a debounced level flips (>= 1)
//   repeat_delay_p     cycles from entry pulse to first auto-repeat pulse (>= 1)
//   repeat_rate_p      cycles between later auto-repeat pulses (>= 1)
//
// Ports:
//   clk_i       single clock, all logic on the rising edge
//   reset_i     synchronous, active-high reset
//   btn_up_i    raw asynchronous up button, active-high
//   btn_down_i  raw asynchronous down button, active-high
//   up_o        registered one-cycle increment strobe
//   down_o      registered one-cycle decrement strobe
//   set_o       registered one-cycle load strobe

module uds_pulse_gen #(
    parameter int unsigned debounce_cycles_p = 16,
    parameter int unsigned repeat_delay_p    = 1024,
    parameter int unsigned repeat_rate_p     = 256
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_up_i,
    input  logic btn_down_i,
    output logic up_o,
    output logic down_o,
    output logic set_o
);

    localparam int unsigned DbW = $clog2(debounce_cycles_p + 1);
    localparam logic [DbW-1:0] DbLimit = DbW'(debounce_cycles_p);

    typedef enum logic [1:0] {
        StIdle,
        StUpHeld,
        StDownHeld,
        StBothHeld
    } state_e;

    // ------------------------------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------------------------------
    logic [1:0] up_sync_q;
    logic [1:0] down_sync_q;
    logic [1:0] sync_lvl;   // [0] = up, [1] = down

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            up_sync_q   <= '0;
            down_sync_q <= '0;
        end else begin
            up_sync_q   <= {up_sync_q[0], btn_up_i};
            down_sync_q <= {down_sync_q[0], btn_down_i};
        end
    end

    assign sync_lvl = {down_sync_q[1], up_sync_q[1]};

    // ------------------------------------------------------------------------------------------
    // Debouncers
    //
    // The counter counts consecutive synchronized samples that disagree with the debounced
    // level. The level flips on the disagreeing sample that arrives with the counter already at
    // the limit. An agreeing sample clears the counter, so it never wraps.
    // ------------------------------------------------------------------------------------------
    logic [DbW-1:0] db_cnt_q [2];
    logic [DbW-1:0] db_cnt_d [2];
    logic [1:0]     db_lvl_q;
    logic [1:0]     db_lvl_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            if (sync_lvl[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DbLimit) begin
                    db_lvl_d[i] = sync_lvl[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            db_lvl_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_lvl_q <= db_lvl_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Auto-repeat timer
    // ------------------------------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    logic   repeat_fire;

`ifdef UDS_PULSE_GEN_AUTO_REPEAT_EN
    localparam int unsigned RptMax = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p
                                                                        : repeat_rate_p;
    localparam int unsigned RptW = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] RptDelay = RptW'(repeat_delay_p);
    localparam logic [RptW-1:0] RptRate  = RptW'(repeat_rate_p);

    // Down-counter of cycles left until the next repeat. It is reloaded with the initial delay
    // whenever the FSM is not staying in a single-held state, so every state change restarts
    // the hold.
    logic [RptW-1:0] rpt_q;
    logic [RptW-1:0] rpt_d;
    logic            single_held;

    assign single_held = (state_q == StUpHeld) || (state_q == StDownHeld);
    assign repeat_fire = single_held && (rpt_q <= RptW'(1));

    always_comb begin
        rpt_d = RptDelay;
        if (single_held && (state_d == state_q)) begin
            rpt_d = repeat_fire ? RptRate : (rpt_q - RptW'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    // The repeat parameters are accepted for interface compatibility but have no effect.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{repeat_delay_p, repeat_rate_p};
    assign repeat_fire       = 1'b0;
`endif

    // ------------------------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------------------------
    logic du;
    logic dd;
    logic up_d;
    logic down_d;
    logic set_d;
    logic up_q;
    logic down_q;
    logic set_q;

    assign du = db_lvl_q[0];
    assign dd = db_lvl_q[1];

    always_comb begin
        state_d = state_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        set_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (du && dd) begin
                    set_d   = 1'b1;
                    state_d = StBothHeld;
                end else if (du) begin
                    up_d    = 1'b1;
                    state_d = StUpHeld;
                end else if (dd) begin
                    down_d  = 1'b1;
                    state_d = StDownHeld;
                end
            end
            StUpHeld: begin
                // The other button wins even if the held one releases in the same cycle.
                if (dd) begin
                    set_d   = 1'b1;
                    state_d = StBothHeld;
                end else if (!du) begin
                    state_d = StIdle;
                end else begin
                    up_d = repeat_fire;
                end
            end
            StDownHeld: begin
                if (du) begin
                    set_d   = 1'b1;
                    state_d = StBothHeld;
                end else if (!dd) begin
                    state_d = StIdle;
                end else begin
                    down_d = repeat_fire;
                end
            end
            StBothHeld: begin
                // Only a full release re-arms; a partial release is ignored.
                if (!du && !dd) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            down_q  <= down_d;
            set_q   <= set_d;
        end
    end

    assign up_o   = up_q;
    assign down_o = down_q;
    assign set_o  = set_q;

endmodule

// File: tb/tb_uds_pulse_gen.sv
// Self-checking bench for uds_pulse_gen.
// The reference model works from the raw button samples. A debounced level flips once the last
// debounce+1 synchronized samples all disagree with it. Strobes are derived from which buttons
// are held, and auto-repeats are computed from the elapsed hold time.

module tb_uds_pulse_gen;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic clk_i;
    logic reset_i;
    logic btn_up_i;
    logic btn_down_i;
    logic up_o;
    logic down_o;
    logic set_o;

    uds_pulse_gen #(
        .debounce_cycles_p(DB),
        .repeat_delay_p   (RD),
        .repeat_rate_p    (RR)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .btn_up_i  (btn_up_i),
        .btn_down_i(btn_down_i),
        .up_o      (up_o),
        .down_o    (down_o),
        .set_o     (set_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    int up_times[$];
    int dn_times[$];
    int set_times[$];

    // Reference model state; hu[j] / hd[j] = raw sample taken j edges ago.
    bit hu[DB+3];
    bit hd[DB+3];
    bit m_du, m_dd;
    int m_mode;      // 0 none held, 1 up, 2 down, 3 both
    int m_elapsed;
    bit e_up, e_dn, e_set;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
        end
    endtask

    function automatic bit all_other(input bit h[DB+3], input bit lvl);
        for (int j = 2; j <= DB + 2; j++) begin
            if (h[j] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit repeat_due(input int el);
`ifdef UDS_PULSE_GEN_AUTO_REPEAT_EN
        return (el >= RD) && ((el - RD) % RR == 0);
`else
        return (el < 0);
`endif
    endfunction

    task automatic model_step(input bit rst, input bit u, input bit d);
        e_up = 0; e_dn = 0; e_set = 0;
        if (rst) begin
            for (int j = 0; j < DB + 3; j++) begin
                hu[j] = 0;
                hd[j] = 0;
            end
            m_du = 0; m_dd = 0; m_mode = 0; m_elapsed = 0;
            return;
        end
        for (int j = DB + 2; j > 0; j--) begin
            hu[j] = hu[j-1];
            hd[j] = hd[j-1];
        end
        hu[0] = u;
        hd[0] = d;
        if (m_mode == 0) begin
            if (m_du && m_dd) begin e_set = 1; m_mode = 3; end
            else if (m_du) begin e_up = 1; m_mode = 1; m_elapsed = 0; end
            else if (m_dd) begin e_dn = 1; m_mode = 2; m_elapsed = 0; end
        end else if (m_mode == 3) begin
            if (!m_du && !m_dd) m_mode = 0;
        end else begin
            if ((m_mode == 1 && m_dd) || (m_mode == 2 && m_du)) begin
                e_set = 1; m_mode = 3;
            end else if ((m_mode == 1 && !m_du) || (m_mode == 2 && !m_dd)) begin
                m_mode = 0;
            end else begin
                m_elapsed++;
                if (repeat_due(m_elapsed)) begin
                    if (m_mode == 1) e_up = 1;
                    else e_dn = 1;
                end
            end
        end
        if (all_other(hu, m_du)) m_du = !m_du;
        if (all_other(hd, m_dd)) m_dd = !m_dd;
    endtask

    task automatic run_cycle(input bit rst, input bit u, input bit d);
        reset_i    = rst;
        btn_up_i   = u;
        btn_down_i = d;
        @(posedge clk_i);
        #1;
        model_step(rst, u, d);
        check_eq("up_o", up_o, e_up);
        check_eq("down_o", down_o, e_dn);
        check_eq("set_o", set_o, e_set);
        check_eq("one_hot", ($countones({up_o, down_o, set_o}) <= 1), 1);
        if (rst) check_eq("reset_quiet", {up_o, down_o, set_o}, 0);
        if (up_o === 1'b1) up_times.push_back(t);
        if (down_o === 1'b1) dn_times.push_back(t);
        if (set_o === 1'b1) set_times.push_back(t);
        t++;
    endtask

    task automatic start_scenario();
        run_cycle(1, 0, 0);
        run_cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0);
        t = 0;
        up_times.delete();
        dn_times.delete();
        set_times.delete();
    endtask

    task automatic first_is(input string tag, input int q[$], input int idx, input int exp);
        check_eq(tag, (q.size() > idx) ? q[idx] : -1, exp);
    endtask

    initial begin
        reset_i    = 1;
        btn_up_i   = 0;
        btn_down_i = 0;

        // Single up press: one pulse at cycle 7.
        start_scenario();
        for (int i = 0; i < 20; i++) run_cycle(0, 1, 0);
        for (int i = 0; i < 20; i++) run_cycle(0, 0, 0);
        check_eq("a_up_count", up_times.size(), 1);
        first_is("a_up_time", up_times, 0, 7);
        check_eq("a_other", dn_times.size() + set_times.size(), 0);

        // Bouncing down button never qualifies.
        start_scenario();
        for (int i = 0; i < 40; i++) run_cycle(0, 0, ((i >> 1) & 1) == 0);
        for (int i = 0; i < 20; i++) run_cycle(0, 0, 0);
        check_eq("b_pulses", up_times.size() + dn_times.size() + set_times.size(), 0);

        // Up held, down added at 30: set at 37, nothing more while both held.
        start_scenario();
        for (int i = 0; i < 50; i++) run_cycle(0, 1, i >= 30);
        for (int i = 0; i < 20; i++) run_cycle(0, 0, 0);
        first_is("c_up_time", up_times, 0, 7);
        check_eq("c_set_count", set_times.size(), 1);
        first_is("c_set_time", set_times, 0, 37);
`ifdef UDS_PULSE_GEN_AUTO_REPEAT_EN
        check_eq("c_up_count", up_times.size(), 3);
`else
        check_eq("c_up_count", up_times.size(), 1);
`endif
        check_eq("c_down_count", dn_times.size(), 0);

        // Long hold: repeats when enabled, ending at 62.
        start_scenario();
        for (int i = 0; i < 60; i++) run_cycle(0, 1, 0);
        for (int i = 0; i < 20; i++) run_cycle(0, 0, 0);
        first_is("d_up_first", up_times, 0, 7);
`ifdef UDS_PULSE_GEN_AUTO_REPEAT_EN
        check_eq("d_up_count", up_times.size(), 9);
        first_is("d_up_second", up_times, 1, 27);
        first_is("d_up_last", up_times, 8, 62);
`else
        check_eq("d_up_count", up_times.size(), 1);
`endif

        // Reset mid-hold: pulse again 7 cycles after reset releases.
        start_scenario();
        for (int i = 0; i < 40; i++) run_cycle(i == 15, 0, 1);
        for (int i = 0; i < 20; i++) run_cycle(0, 0, 0);
        first_is("e_dn_first", dn_times, 0, 7);
        first_is("e_dn_second", dn_times, 1, 23);
`ifdef UDS_PULSE_GEN_AUTO_REPEAT_EN
        check_eq("e_dn_count", dn_times.size(), 3);
`else
        check_eq("e_dn_count", dn_times.size(), 2);
`endif

        // Random holds with bounce and occasional reset.
        begin
            bit u, d;
            int len;
            u = 0; d = 0;
            for (int seg = 0; seg < 120; seg++) begin
                u = $urandom_range(0, 1);
                d = ($urandom_range(0, 3) == 0);
                len = $urandom_range(1, 45);
                for (int i = 0; i < len; i++) begin
                    bit bu, bd, rs;
                    bu = ($urandom_range(0, 9) == 0) ? !u : u;
                    bd = ($urandom_range(0, 9) == 0) ? !d : d;
                    rs = ($urandom_range(0, 299) == 0);
                    run_cycle(rs, bu, bd);
                end
            end
            for (int i = 0; i < 20; i++) run_cycle(0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uds_pulse_gen.md
UDS_PULSE_GEN -- requirements
Module: uds_pulse_gen

Interface
- REQ-001 SHALL have parameter debounce_cycles_p, default 16, meaning the number of consecutive stable cycles required before a debounced level changes (legal range at least 1).
- REQ-002 SHALL have parameter repeat_delay_p, default 1024, meaning the hold time in cycles from the first pulse to the first auto-repeat pulse (legal range at least 1).
- REQ-003 SHALL have parameter repeat_rate_p, default 256, meaning the period in cycles between subsequent auto-repeat pulses (legal range at least 1).
- REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-005 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
- REQ-006 SHALL have port btn_up_i, input, 1 bit: raw asynchronous up button, active-high.
- REQ-007 SHALL have port btn_down_i, input, 1 bit: raw asynchronous down button, active-high.
- REQ-008 SHALL have port up_o, output, 1 bit: one-cycle increment strobe to the downstream up/down/set counter.
- REQ-009 SHALL have port down_o, output, 1 bit: one-cycle decrement strobe.
- REQ-010 SHALL have port set_o, output, 1 bit: one-cycle load strobe.

Function
- REQ-011 SHALL pass each button through a 2-flop synchronizer before any other use.
- REQ-012 SHALL debounce each synchronized input independently: the debounced level flips only after the synchronized value has differed from it for debounce_cycles_p consecutive cycles; any agreeing cycle clears that input's count.
- REQ-013 SHALL implement the FSM states IDLE, UP_HELD, DOWN_HELD and BOTH_HELD, driven by the debounced levels (du, dd).
- REQ-014 SHALL, in IDLE: on du=1, dd=0, pulse up_o and go to UP_HELD; on du=0, dd=1, pulse down_o and go to DOWN_HELD; on du=1, dd=1 in the same cycle, pulse set_o only and go to BOTH_HELD.
- REQ-015 SHALL, in UP_HELD or DOWN_HELD: go to IDLE with no pulse when the held input releases; pulse set_o and go to BOTH_HELD when the other input asserts, including the case where the held input releases in the same cycle.
- REQ-016 SHALL, in BOTH_HELD, emit no pulses and return to IDLE only when du=0 and dd=0; a partial release stays in BOTH_HELD.
- REQ-017 SHALL register all outputs, each high for exactly one cycle per event, with at most one of up_o, down_o and set_o high in any cycle.
- REQ-018 SHALL produce the first pulse exactly debounce_cycles_p+3 cycles after the first rising clock edge at which the raw input is sampled changed and then held stable.
- REQ-019 SHALL size each internal counter to $clog2(param+1) bits and saturate or clear each counter, never wrapping.

Reset
- REQ-020 SHALL, while reset_i=1 at a clock edge, clear the synchronizer flops, debounced levels, debounce counters and repeat timer to 0, force the FSM to IDLE, and drive up_o, down_o and set_o to 0.
- REQ-021 SHALL abort any hold or repeat sequence when reset is asserted mid-operation; a button still held after reset deasserts is treated as a new press, pulsing once at debounce_cycles_p+3 cycles.

Configuration
- REQ-022 SHALL, when macro UDS_PULSE_GEN_AUTO_REPEAT_EN is defined, pulse the held direction in UP_HELD or DOWN_HELD repeat_delay_p cycles after the entry pulse and then every repeat_rate_p cycles while held; the repeat timer reloads on every state change.
- REQ-023 SHALL, when UDS_PULSE_GEN_AUTO_REPEAT_EN is undefined, omit the repeat timer entirely, ignore repeat_delay_p and repeat_rate_p, and emit exactly one pulse per press.

Verification (debounce_cycles_p=4, repeat_delay_p=20, repeat_rate_p=5)
- REQ-024 SHALL cover: btn_up_i rises at cycle 0 and holds -> single up_o at cycle 7; no down_o or set_o.
- REQ-025 SHALL cover: btn_down_i toggling every 2 cycles for 40 cycles, then low -> no output pulses.
- REQ-026 SHALL cover: btn_up_i held at cycle 0, btn_down_i added at cycle 30 -> up_o at cycle 7, set_o at cycle 37, and no further pulses until both are released and re-pressed.
- REQ-027 SHALL cover, with the macro defined: btn_up_i held for 60 cycles -> up_o at cycles 7, 27, 32, 37, ... 62 (the last one covering the hold-time debounce tail); with the macro undefined -> up_o at cycle 7 only.
- REQ-028 SHALL cover: reset_i pulsed at cycle 15 while btn_down_i is held from cycle 0 -> down_o at cycle 7, all outputs 0 during reset, and down_o again at cycle 16+7=23.
